debug_frame_tx: RTL and testbench

DEBUG_FRAME_TX -- requirements
Module: debug_frame_tx

---
 rtl/debug_frame_tx.sv | 155 +++++++++++++++
 tb/tb_debug_frame_tx.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_frame_tx.sv
// debug_frame_tx
// Serialises a debug payload into a byte frame for a uart_tx:
//   HEADER, length byte, payload bytes 0..N-1 (LSB byte first), XOR checksum.
// Ports:
//   i_clk, i_reset     clock, asynchronous active-high reset
//   i_start            single-cycle frame request (accepted only in IDLE)
//   i_data             payload, byte k = i_data[8k+7:8k]
//   i_num_bytes        payload byte count N (0..DATA_WIDTH/8 accepted)
//   i_abort            cancel the current frame
//   i_tx_done          uart_tx byte-complete pulse
//   o_tx_start         one-cycle byte strobe to uart_tx
//   o_tx_data          byte presented to uart_tx, held until its i_tx_done
//   o_busy             high in SEND and WAIT
//   o_done             one-cycle pulse when a frame completes
//   o_error            one-cycle pulse when a request is rejected (N too large)
//   o_dbg_state        {phase, state} for observation
// Handshake: o_tx_start pulses exactly once per byte; the byte is considered
// finished only on the i_tx_done that arrives while waiting for it. i_tx_done
// at any other time is ignored.
module debug_frame_tx #(
  parameter int          DATA_WIDTH = 1024,
  parameter int          LEN_WIDTH  = 8,
  parameter logic [7:0]  HEADER     = 8'hA5
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [LEN_WIDTH-1:0]  i_num_bytes,
  input  logic                  i_abort,
  input  logic                  i_tx_done,
  output logic                  o_tx_start,
  output logic [7:0]            o_tx_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [3:0]            o_dbg_state
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int CW = $clog2(NB) + 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;
  typedef enum logic [1:0] {HDR, LEN, PAY, CHK} phase_t;

  state_t                state;
  phase_t                phase;
  logic [DATA_WIDTH-1:0] snap_data;
  logic [CW-1:0]         snap_len;
  logic [7:0]            len_byte;
  logic [CW-1:0]         idx;
  logic [7:0]            chk;

  logic [DATA_WIDTH-1:0] shifted;
  logic [7:0]            pay_byte;
  logic                  len_ok;

  // Payload byte currently addressed by idx.
  assign shifted  = snap_data >> {idx, 3'b000};
  assign pay_byte = shifted[7:0];
  assign len_ok   = (int'(i_num_bytes) <= NB);

  assign o_dbg_state = {phase, state};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= IDLE;
      phase      <= HDR;
      snap_data  <= '0;
      snap_len   <= '0;
      len_byte   <= 8'h00;
      idx        <= '0;
      chk        <= 8'h00;
      o_tx_start <= 1'b0;
      o_tx_data  <= 8'h00;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_error    <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_done     <= 1'b0;
      o_error    <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            if (len_ok) begin
              snap_data  <= i_data;
              snap_len   <= CW'(i_num_bytes);
              len_byte   <= 8'(i_num_bytes);
              chk        <= 8'h00;
              idx        <= '0;
              phase      <= HDR;
              state      <= SEND;
              o_tx_start <= 1'b1;
              o_tx_data  <= HEADER;
              o_busy     <= 1'b1;
            end else begin
              o_error <= 1'b1;
            end
          end
        end
        SEND: begin
          if (i_abort) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          // Abort wins over a coincident i_tx_done.
          if (i_abort) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end else if (i_tx_done) begin
            case (phase)
              HDR: begin
                phase      <= LEN;
                state      <= SEND;
                o_tx_start <= 1'b1;
                o_tx_data  <= len_byte;
              end
              LEN, PAY: begin
                // Leaving LEN idx is 0, so one comparison covers both the
                // empty payload and the end of a non-empty one.
                if (idx == snap_len) begin
                  phase     <= CHK;
                  o_tx_data <= chk;
                end else begin
                  phase     <= PAY;
                  o_tx_data <= pay_byte;
                  chk       <= chk ^ pay_byte;
                  idx       <= idx + CW'(1);
                end
                state      <= SEND;
                o_tx_start <= 1'b1;
              end
              CHK: begin
                state  <= DONE;
                o_done <= 1'b1;
                o_busy <= 1'b0;
              end
              default: state <= IDLE;
            endcase
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_frame_tx.sv
module tb_debug_frame_tx;

  localparam int DW = 1024;
  localparam int LW = 8;

  logic          clk;
  logic          i_reset;
  logic          i_start;
  logic [DW-1:0] i_data;
  logic [LW-1:0] i_num_bytes;
  logic          i_abort;
  logic          i_tx_done;
  logic          o_tx_start;
  logic [7:0]    o_tx_data;
  logic          o_busy;
  logic          o_done;
  logic          o_error;
  logic [3:0]    o_dbg_state;

  debug_frame_tx #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .HEADER(8'hA5)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_data(i_data),
    .i_num_bytes(i_num_bytes), .i_abort(i_abort), .i_tx_done(i_tx_done),
    .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .o_busy(o_busy),
    .o_done(o_done), .o_error(o_error), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int n_start = 0;
  int n_done = 0;
  int n_err = 0;
  logic [7:0] held = 8'h00;
  logic uart_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] e;
    if (!i_reset) begin
      if (o_tx_start) begin
        n_start++;
        held = o_tx_data;
        if (exp_q.size() == 0) check("unexpected_tx_start", 32'(o_tx_data), 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          check("tx_byte", 32'(o_tx_data), 32'(e));
        end
      end
      if (o_done) n_done++;
      if (o_error) n_err++;
    end
  end

  // uart_tx model: 10-cycle byte time, gives up on reset.
  initial begin
    bit aborted;
    i_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      while (o_tx_start && !i_reset) begin
        uart_busy = 1'b1;
        aborted = 1'b0;
        for (int k = 0; k < 9; k++) begin
          @(negedge clk);
          if (i_reset) begin
            aborted = 1'b1;
            break;
          end
        end
        if (!aborted) begin
          check("tx_data_hold", 32'(o_tx_data), 32'(held));
          i_tx_done = 1'b1;
        end
        @(negedge clk);
        i_tx_done = 1'b0;
        uart_busy = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Caller positions at a negedge; request is sampled at the next posedge.
  task automatic start_frame(input logic [DW-1:0] d, input logic [LW-1:0] n,
                             input logic [7:0] c, input logic err);
    if (!err) begin
      exp_q.push_back(8'hA5);
      exp_q.push_back(n);
      for (int i = 0; i < int'(n); i++) exp_q.push_back(d[8*i +: 8]);
      exp_q.push_back(c);
    end
    i_data = d;
    i_num_bytes = n;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check("start_latency", 32'(o_tx_start), 32'(!err));
    check("error_pulse", 32'(o_error), 32'(err));
    check("busy_after_start", 32'(o_busy), 32'(!err));
  endtask

  task automatic wait_done();
    int t = 0;
    while (!o_done && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", 32'(o_done), 32'd1);
    check("busy_in_done", 32'(o_busy), 32'd0);
    @(negedge clk);
    check("done_single_pulse", 32'(o_done), 32'd0);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_starts(input int base, input int cnt);
    int t = 0;
    while ((n_start - base) < cnt && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("reach_byte", 32'(n_start - base), 32'(cnt));
  endtask

  task automatic run_frame(input logic [DW-1:0] d, input logic [LW-1:0] n,
                           input logic [7:0] c, input logic err);
    int s0, d0, e0;
    while (uart_busy) @(negedge clk);
    @(negedge clk);
    s0 = n_start;
    d0 = n_done;
    e0 = n_err;
    start_frame(d, n, c, err);
    if (err) begin
      repeat (5) @(negedge clk);
      check("err_no_start", 32'(n_start - s0), 32'd0);
      check("err_count", 32'(n_err - e0), 32'd1);
      check("err_busy", 32'(o_busy), 32'd0);
    end else begin
      wait_done();
      check("byte_count", 32'(n_start - s0), 32'(int'(n) + 3));
      check("done_count", 32'(n_done - d0), 32'd1);
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [31:0] data;
    logic [7:0]  n;
    logic [7:0]  chk;
    logic        err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int s0, d0;
    vecs[0] = '{32'h11223344, 8'd4,   8'h44, 1'b0};
    vecs[1] = '{32'h55667788, 8'd0,   8'h00, 1'b0};
    vecs[2] = '{32'h000000AB, 8'd1,   8'hAB, 1'b0};
    vecs[3] = '{32'h00C0FFEE, 8'd3,   8'hD1, 1'b0};
    vecs[4] = '{32'h11223344, 8'd129, 8'h00, 1'b1};
    vecs[5] = '{32'h11223344, 8'd128, 8'h44, 1'b0};
    vecs[6] = '{32'h80000001, 8'd255, 8'h00, 1'b1};

    i_reset = 1'b1;
    i_start = 1'b0;
    i_data = '0;
    i_num_bytes = '0;
    i_abort = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_start", 32'(o_tx_start), 32'd0);
    check("rst_tx_data", 32'(o_tx_data), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_error", 32'(o_error), 32'd0);
    i_reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++)
      run_frame(DW'(vecs[i].data), vecs[i].n, vecs[i].chk, vecs[i].err);

    // Second request and data change in mid-frame must not disturb it.
    while (uart_busy) @(negedge clk);
    @(negedge clk);
    s0 = n_start;
    d0 = n_done;
    start_frame(DW'(32'h11223344), 8'd4, 8'h44, 1'b0);
    repeat (15) @(negedge clk);
    i_data = DW'(32'hDEADBEEF);
    i_num_bytes = 8'd2;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_done();
    repeat (20) @(negedge clk);
    check("midstart_bytes", 32'(n_start - s0), 32'd7);
    check("midstart_done", 32'(n_done - d0), 32'd1);

    // Abort while waiting on payload byte 2.
    while (uart_busy) @(negedge clk);
    @(negedge clk);
    s0 = n_start;
    d0 = n_done;
    start_frame(DW'(32'hA1B2C3D4), 8'd4, 8'h04, 1'b0);
    wait_starts(s0, 5);
    @(negedge clk);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_tx_start", 32'(o_tx_start), 32'd0);
    exp_q.delete();
    repeat (30) @(negedge clk);
    check("abort_no_more_bytes", 32'(n_start - s0), 32'd5);
    check("abort_no_done", 32'(n_done - d0), 32'd0);
    run_frame(DW'(32'h11223344), 8'd4, 8'h44, 1'b0);

    // Reset during the LEN byte, then restart on the first cycle after release.
    while (uart_busy) @(negedge clk);
    @(negedge clk);
    s0 = n_start;
    d0 = n_done;
    start_frame(DW'(32'h11223344), 8'd4, 8'h44, 1'b0);
    wait_starts(s0, 2);
    @(negedge clk);
    i_reset = 1'b1;
    #1;
    check("midrst_tx_start", 32'(o_tx_start), 32'd0);
    check("midrst_tx_data", 32'(o_tx_data), 32'd0);
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_done", 32'(o_done), 32'd0);
    check("midrst_error", 32'(o_error), 32'd0);
    repeat (4) @(negedge clk);
    exp_q.delete();
    d0 = n_done;
    s0 = n_start;
    i_reset = 1'b0;
    start_frame(DW'(32'h00C0FFEE), 8'd3, 8'hD1, 1'b0);
    wait_done();
    check("postrst_bytes", 32'(n_start - s0), 32'd6);
    check("postrst_done", 32'(n_done - d0), 32'd1);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
